// File: rtl/shared_ram_rr_pkg.sv
// Shared types and helpers for the multi-port round-robin shared RAM.
package shared_ram_rr_pkg;

    typedef enum logic {
        ARB_FREE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // Width of a port index; a single-bit index is kept even for tiny port counts.
    function automatic int port_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/shared_ram_rr_arbiter.sv
// Round-robin arbiter with atomic lock ownership: one grant per cycle,
// search starts at the rotating pointer, a locking grantee keeps exclusive access.
module rr_arbiter
    import shared_ram_rr_pkg::*;
#(
    parameter int N_PORTS = 4,
    parameter int PORT_W  = port_w(N_PORTS)
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic [N_PORTS-1:0] req,
    input  logic [N_PORTS-1:0] lock,
    input  logic              enable,
    output logic [N_PORTS-1:0] gnt,
    output logic [PORT_W-1:0] gnt_idx,
    output logic              valid
);

    arb_state_t        r_state;
    arb_state_t        w_state_next;
    logic [PORT_W-1:0] r_ptr;
    logic [PORT_W-1:0] w_ptr_next;
    logic [PORT_W-1:0] r_owner;
    logic [PORT_W-1:0] w_owner_next;
    logic [PORT_W-1:0] w_pick;
    logic              w_found;

    function automatic logic [PORT_W-1:0] next_port(input logic [PORT_W-1:0] k);
        return PORT_W'((int'(k) + 1) % N_PORTS);
    endfunction

    always_comb begin
        w_pick       = '0;
        w_found      = 1'b0;
        gnt          = '0;
        gnt_idx      = '0;
        valid        = 1'b0;
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_owner_next = r_owner;

        for (int off = 0; off < N_PORTS; off++) begin
            if (!w_found && req[(int'(r_ptr) + off) % N_PORTS]) begin
                w_found = 1'b1;
                w_pick  = PORT_W'((int'(r_ptr) + off) % N_PORTS);
            end
        end

        // While locked only the owner may be granted; the pointer is frozen.
        if (r_state == ARB_LOCKED) begin
            gnt_idx = r_owner;
            valid   = enable & rstN & req[r_owner];
        end else begin
            gnt_idx = w_pick;
            valid   = enable & rstN & w_found;
        end
        if (valid) begin
            gnt[gnt_idx] = 1'b1;
        end

        case (r_state)
            ARB_FREE: begin
                if (valid) begin
                    w_ptr_next = next_port(gnt_idx);
                    if (lock[gnt_idx]) begin
                        w_state_next = ARB_LOCKED;
                        w_owner_next = gnt_idx;
                    end
                end
            end
            ARB_LOCKED: begin
                if (!req[r_owner] || (valid && !lock[r_owner])) begin
                    w_state_next = ARB_FREE;
                    w_ptr_next   = next_port(r_owner);
                end
            end
            default: w_state_next = ARB_FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_state <= ARB_FREE;
            r_ptr   <= '0;
            r_owner <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
            r_owner <= w_owner_next;
        end
    end

endmodule

// File: rtl/shared_ram_rr.sv
// Single-port synchronous RAM shared by N_PORTS cores through a round-robin
// arbiter; reads return one cycle after the grant on a shared, tagged output.
module shared_ram_rr
    import shared_ram_rr_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int N_PORTS    = 4,
    parameter int PORT_W     = port_w(N_PORTS)
) (
    input  logic                          clk,
    input  logic                          rstN,
    input  logic [N_PORTS-1:0]            req,
    input  logic [N_PORTS-1:0]            wrEn,
    input  logic [N_PORTS-1:0]            lock,
    input  logic [N_PORTS*ADDR_WIDTH-1:0] address,
    input  logic [N_PORTS*DATA_WIDTH-1:0] dataIn,
    output logic [N_PORTS-1:0]            gnt,
    output logic [N_PORTS-1:0]            rdValid,
    output logic [PORT_W-1:0]             rdPort,
    output logic [DATA_WIDTH-1:0]         dataOut
);

    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] w_addr [N_PORTS];
    logic [DATA_WIDTH-1:0] w_din  [N_PORTS];
    logic [PORT_W-1:0]     w_gnt_idx;
    logic                  w_gnt_valid;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_din;
    logic                  w_sel_wr;
    logic                  w_in_range;
    logic                  w_do_wr;
    logic                  w_do_rd;
    logic [N_PORTS-1:0]    r_rd_valid;
    logic [PORT_W-1:0]     r_rd_port;
    logic [DATA_WIDTH-1:0] r_data;

    generate
        for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_unpack
            assign w_addr[gi] = address[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_din[gi]  = dataIn[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    rr_arbiter #(
        .N_PORTS(N_PORTS),
        .PORT_W (PORT_W)
    ) u_arb (
        .clk    (clk),
        .rstN   (rstN),
        .req    (req),
        .lock   (lock),
        .enable (1'b1),
        .gnt    (gnt),
        .gnt_idx(w_gnt_idx),
        .valid  (w_gnt_valid)
    );

    assign w_sel_addr = w_addr[w_gnt_idx];
    assign w_sel_din  = w_din[w_gnt_idx];
    assign w_sel_wr   = wrEn[w_gnt_idx];
    // Out-of-range addresses only exist for non-power-of-two depths.
    assign w_in_range = {1'b0, w_sel_addr} < DEPTH_LIM;
    assign w_do_wr    = w_gnt_valid & w_sel_wr & w_in_range;
    assign w_do_rd    = w_gnt_valid & ~w_sel_wr;

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[w_sel_addr] <= w_sel_din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_rd_valid <= '0;
            r_rd_port  <= '0;
            r_data     <= '0;
        end else begin
            r_rd_valid <= '0;
            if (w_do_rd) begin
                r_rd_valid <= gnt;
                r_rd_port  <= w_gnt_idx;
                r_data     <= w_in_range ? r_mem[w_sel_addr] : '0;
            end
        end
    end

    assign rdValid = r_rd_valid;
    assign rdPort  = r_rd_port;
    assign dataOut = r_data;

endmodule

// File: tb/tb_shared_ram_rr.sv
// Directed and randomized bench for shared_ram_rr against a behavioural model
// of memory contents, rotation pointer and lock owner.
module tb_shared_ram_rr;

    localparam int DW    = 12;
    localparam int DEPTH = 256;
    localparam int AW    = 8;
    localparam int N     = 4;
    localparam int PW    = 2;

    logic            clk  = 1'b0;
    logic            rstN = 1'b0;
    logic [N-1:0]    req;
    logic [N-1:0]    wrEn;
    logic [N-1:0]    lock;
    logic [N*AW-1:0] address;
    logic [N*DW-1:0] dataIn;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rdValid;
    logic [PW-1:0]   rdPort;
    logic [DW-1:0]   dataOut;

    always #5 clk = ~clk;

    shared_ram_rr #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .N_PORTS(N), .PORT_W(PW)
    ) dut (
        .clk(clk), .rstN(rstN), .req(req), .wrEn(wrEn), .lock(lock),
        .address(address), .dataIn(dataIn), .gnt(gnt), .rdValid(rdValid),
        .rdPort(rdPort), .dataOut(dataOut)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_mem [DEPTH];
    int m_ptr   = 0;
    int m_owner = -1;
    int m_rv    = 0;
    int m_port  = 0;
    int m_data  = 0;
    int last_g  = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant();
        if (!rstN) return -1;
        if (m_owner >= 0) return req[m_owner] ? m_owner : -1;
        for (int off = 0; off < N; off++) begin
            if (req[(m_ptr + off) % N]) return (m_ptr + off) % N;
        end
        return -1;
    endfunction

    task automatic model_update(input int g);
        int a;
        if (!rstN) begin
            m_ptr = 0; m_owner = -1; m_rv = 0; m_port = 0; m_data = 0;
            return;
        end
        m_rv = 0;
        if (g >= 0) begin
            a = int'(address[g*AW +: AW]);
            if (wrEn[g]) begin
                if (a < DEPTH) m_mem[a] = int'(dataIn[g*DW +: DW]);
            end else begin
                m_rv   = 1 << g;
                m_port = g;
                m_data = (a < DEPTH) ? m_mem[a] : 0;
            end
        end
        if (m_owner < 0) begin
            if (g >= 0) begin
                m_ptr = (g + 1) % N;
                if (lock[g]) m_owner = g;
            end
        end else if (!req[m_owner] || (g == m_owner && !lock[m_owner])) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
        end
    endtask

    // One clock: compare at the falling edge, commit the model at the rising edge.
    task automatic step();
        int g;
        @(negedge clk);
        g = model_grant();
        check("gnt", 32'(gnt), (g >= 0) ? 32'(1 << g) : 32'd0);
        check("rdValid", 32'(rdValid), 32'(m_rv));
        check("rdPort", 32'(rdPort), 32'(m_port));
        check("dataOut", 32'(dataOut), 32'(m_data));
        @(posedge clk);
        model_update(g);
        last_g = g;
        #1;
    endtask

    task automatic clear_all();
        req  = '0;
        wrEn = '0;
        lock = '0;
    endtask

    task automatic set_port(input int p, input bit r, input bit w, input bit l,
                            input int a, input int d);
        req[p]  = r;
        wrEn[p] = w;
        lock[p] = l;
        address[p*AW +: AW] = AW'(a);
        dataIn[p*DW +: DW]  = DW'(d);
    endtask

    initial begin
        int old;
        clear_all();
        address = '0;
        dataIn  = '0;
        repeat (2) @(posedge clk);
        #1;
        step();
        check("reset_rdValid", 32'(rdValid), 32'd0);
        check("reset_dataOut", 32'(dataOut), 32'd0);
        rstN = 1'b1;

        // Fill memory so every later read has a defined expectation
        for (int i = 0; i < DEPTH; i++) begin
            set_port(0, 1, 1, 0, i, (i * 37 + 5) & 12'hFFF);
            step();
        end
        clear_all();

        // Single write then read by port 2
        set_port(2, 1, 1, 0, 5, 12'hABC);
        #1 check("t1_wr_gnt", 32'(gnt), 32'b0100);
        step();
        set_port(2, 1, 0, 0, 5, 0);
        #1 check("t1_rd_gnt", 32'(gnt), 32'b0100);
        step();
        clear_all();
        check("t1_rdValid", 32'(rdValid), 32'b0100);
        check("t1_rdPort", 32'(rdPort), 32'd2);
        check("t1_data", 32'(dataOut), 32'hABC);
        step();

        // Full contention from a freshly reset pointer
        rstN = 1'b0;
        step();
        rstN = 1'b1;
        for (int p = 0; p < N; p++) set_port(p, 1, 0, 0, 20 + p, 0);
        for (int c = 0; c < 8; c++) begin
            #1 check("cont_gnt", 32'(gnt), 32'(1 << (c % 4)));
            if (c > 0) check("cont_rdPort", 32'(rdPort), 32'((c - 1) % 4));
            step();
        end
        clear_all();
        step();

        // Atomic increment by port 1 while ports 0 and 3 contend
        set_port(0, 1, 0, 0, 7, 0);
        step();
        clear_all();
        set_port(0, 1, 0, 0, 10, 0);
        set_port(3, 1, 0, 0, 10, 0);
        set_port(1, 1, 0, 1, 10, 0);
        #1 check("lock_gnt_rd", 32'(gnt), 32'b0010);
        step();
        old = m_mem[10];
        set_port(1, 1, 1, 0, 10, (old + 1) & 12'hFFF);
        #1 check("lock_gnt_wr", 32'(gnt), 32'b0010);
        check("lock_rd_data", 32'(dataOut), 32'(old));
        step();
        set_port(1, 0, 0, 0, 0, 0);
        #1 check("unlock_gnt3", 32'(gnt), 32'b1000);
        step();
        set_port(3, 0, 0, 0, 0, 0);
        #1 check("unlock_gnt0", 32'(gnt), 32'b0001);
        step();
        set_port(0, 0, 0, 0, 0, 0);
        check("lock_incr", 32'(dataOut), 32'((old + 1) & 12'hFFF));
        step();

        // Read-after-write across ports at the top address
        set_port(0, 1, 1, 0, 255, 12'h123);
        step();
        clear_all();
        set_port(3, 1, 0, 0, 255, 0);
        step();
        clear_all();
        check("raw_data", 32'(dataOut), 32'h123);
        check("raw_rv", 32'(rdValid), 32'b1000);
        step();

        // Reset asserted while port 1 requests a read
        set_port(1, 1, 0, 0, 5, 0);
        rstN = 1'b0;
        #1 check("rst_gnt", 32'(gnt), 32'd0);
        step();
        check("rst_rdValid", 32'(rdValid), 32'd0);
        check("rst_dataOut", 32'(dataOut), 32'd0);
        rstN = 1'b1;
        #1 check("rst_release_gnt", 32'(gnt), 32'b0010);
        step();
        clear_all();
        check("rst_retained", 32'(dataOut), 32'hABC);
        check("rst_retained_rv", 32'(rdValid), 32'b0010);
        step();

        // Idle: outputs hold, pointer stays after port 1
        repeat (5) step();
        for (int p = 0; p < N; p++) set_port(p, 1, 0, 0, p, 0);
        #1 check("idle_ptr_gnt", 32'(gnt), 32'b0100);
        step();
        clear_all();

        // Randomized traffic with held requests, locks and rare resets
        for (int c = 0; c < 600; c++) begin
            rstN = ($urandom_range(0, 99) != 0);
            for (int p = 0; p < N; p++) begin
                if (!req[p] || p == last_g) begin
                    set_port(p, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                             $urandom_range(0, 3) == 0, $urandom_range(0, DEPTH - 1),
                             $urandom_range(0, 4095));
                end
            end
            step();
        end
        clear_all();
        rstN = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
